// File: rtl/hba_arbiter_pkg.sv
// Shared definitions for the HBA bus arbiter slice.
//   - arbiter FSM state encodings (ARB_IDLE / ARB_GRANT / ARB_GAP)
//   - HBA bus width defaults used across the bus fabric
//   - helper sizing the per-grant transfer counter
package hba_arbiter_pkg;

   localparam logic [1:0] ARB_IDLE  = 2'd0;
   localparam logic [1:0] ARB_GRANT = 2'd1;
   localparam logic [1:0] ARB_GAP   = 2'd2;

   localparam int DBUS_WIDTH        = 8;
   localparam int PERIPH_ADDR_WIDTH = 4;
   localparam int REG_ADDR_WIDTH    = 8;

   // Counter width able to hold 0..max_xfers; an unlimited quota still
   // keeps a 1-bit counter so the datapath never collapses to zero width.
   function automatic int cnt_width(input int max_xfers);
      return (max_xfers > 0) ? $clog2(max_xfers + 1) : 1;
   endfunction

endpackage

// File: rtl/hba_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req       in   NUM_MASTERS  request vector
//   last_idx  in   IDX_WIDTH    index of the previous winner
//   win_oh    out  NUM_MASTERS  one-hot winner (zero when no request)
//   win_idx   out  IDX_WIDTH    winner index (0 when no request)
//   any_req   out  1            at least one request present
// The request vector is duplicated so the search window (last_idx+1 ..
// last_idx+NUM_MASTERS) is contiguous; everything at or below last_idx is
// masked off and the lowest surviving bit wins.
module hba_arbiter_rr_pick
   import hba_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS = 4,
   parameter int IDX_WIDTH   = 3
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [IDX_WIDTH-1:0]   last_idx,
   output logic [NUM_MASTERS-1:0] win_oh,
   output logic [IDX_WIDTH-1:0]   win_idx,
   output logic                   any_req
);

   logic [2*NUM_MASTERS-1:0] req_dbl;
   logic [2*NUM_MASTERS-1:0] mask;
   logic [2*NUM_MASTERS-1:0] masked;

   always_comb begin
      req_dbl = {req, req};
      mask    = '0;
      for (int i = 0; i < 2*NUM_MASTERS; i++) begin
         mask[i] = (i > int'(last_idx));
      end
      masked  = req_dbl & mask;
      win_idx = '0;
      // Descending scan: the last hit written is the lowest set bit.
      for (int i = 2*NUM_MASTERS-1; i >= 0; i--) begin
         if (masked[i]) begin
            win_idx = IDX_WIDTH'(i % NUM_MASTERS);
         end
      end
      any_req = |req;
      win_oh  = any_req ? (NUM_MASTERS'(1) << win_idx) : '0;
   end

endmodule

// File: rtl/hba_arbiter.sv
// Round-robin multi-master arbiter for the HomeBrew Automation Bus.
// Grants one master at a time, limits each grant to MAX_XFERS transfers
// while others wait, and inserts one dead cycle between grants.
// Ports:
//   hba_clk         in   1            bus clock
//   hba_reset_n     in   1            async active-low reset
//   master_request  in   NUM_MASTERS  per-master request (level)
//   master_select   in   1            transfer in progress on the bus
//   hba_xferack     in   1            slave transfer-complete pulse
//   hba_mgrant      out  NUM_MASTERS  one-hot grant (registered)
//   arb_owner       out  IDX_WIDTH    current grant holder
//   arb_busy        out  1            a grant is active
//   arb_preempt     out  1            pulse when a grant is revoked by quota
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ARB_IDLE  | no grant; arbitrate any request, grant next cycle
// ARB_GRANT | owner holds bus; count xferacks, release or preempt
// ARB_GAP   | one dead turnaround cycle; arbitrates exactly like IDLE
module hba_arbiter
   import hba_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS = 4,
   parameter int MAX_XFERS   = 8,
   parameter int IDX_WIDTH   = 3
) (
   input  logic                   hba_clk,
   input  logic                   hba_reset_n,
   input  logic [NUM_MASTERS-1:0] master_request,
   input  logic                   master_select,
   input  logic                   hba_xferack,
   output logic [NUM_MASTERS-1:0] hba_mgrant,
   output logic [IDX_WIDTH-1:0]   arb_owner,
   output logic                   arb_busy,
   output logic                   arb_preempt
);

   localparam int             CNT_W   = cnt_width(MAX_XFERS);
   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'((MAX_XFERS > 0) ? MAX_XFERS : 1);

   if (NUM_MASTERS > 2**IDX_WIDTH) begin : g_param_check
      $error("hba_arbiter: NUM_MASTERS does not fit in IDX_WIDTH");
   end

   logic [1:0]             state,      state_n;
   logic [IDX_WIDTH-1:0]   last_owner, last_owner_n;
   logic [CNT_W-1:0]       xfer_cnt,   xfer_cnt_n;
   logic [NUM_MASTERS-1:0] grant_n;
   logic [IDX_WIDTH-1:0]   owner_n;
   logic                   busy_n;
   logic                   preempt_n;

   logic [NUM_MASTERS-1:0] pick_oh;
   logic [IDX_WIDTH-1:0]   pick_idx;
   logic                   pick_any;

   logic                   owner_req;
   logic                   others_req;
   logic [CNT_W-1:0]       cnt_inc;
   logic                   quota_hit;
   logic                   release_ok;
   logic                   revoke_quota;

   hba_arbiter_rr_pick #(
      .NUM_MASTERS (NUM_MASTERS),
      .IDX_WIDTH   (IDX_WIDTH)
   ) u_rr_pick (
      .req      (master_request),
      .last_idx (last_owner),
      .win_oh   (pick_oh),
      .win_idx  (pick_idx),
      .any_req  (pick_any)
   );

   // The one-hot grant doubles as the owner mask, so no index decode is needed.
   assign owner_req    = |(master_request & hba_mgrant);
   assign others_req   = |(master_request & ~hba_mgrant);
   assign cnt_inc      = (hba_xferack && (xfer_cnt != CNT_SAT)) ? xfer_cnt + CNT_W'(1) : xfer_cnt;
   assign quota_hit    = (MAX_XFERS != 0) && hba_xferack && (cnt_inc == CNT_SAT);
   assign release_ok   = !owner_req && !master_select;
   // Quota revocation is only ever evaluated on an xferack, which is the one
   // cycle a transfer may be cut even with select still high.
   assign revoke_quota = quota_hit && others_req;

   always_comb begin
      state_n      = state;
      last_owner_n = last_owner;
      xfer_cnt_n   = xfer_cnt;
      grant_n      = hba_mgrant;
      owner_n      = arb_owner;
      busy_n       = arb_busy;
      preempt_n    = 1'b0;
      case (state)
         ARB_GRANT: begin
            xfer_cnt_n = cnt_inc;
            if (revoke_quota || release_ok) begin
               grant_n      = '0;
               busy_n       = 1'b0;
               last_owner_n = arb_owner;
               preempt_n    = revoke_quota && !release_ok;
               state_n      = ARB_GAP;
            end
         end
         default: begin
            grant_n = '0;
            busy_n  = 1'b0;
            state_n = ARB_IDLE;
            if (pick_any) begin
               grant_n    = pick_oh;
               owner_n    = pick_idx;
               busy_n     = 1'b1;
               xfer_cnt_n = '0;
               state_n    = ARB_GRANT;
            end
         end
      endcase
   end

   always_ff @(posedge hba_clk or negedge hba_reset_n) begin
      if (!hba_reset_n) begin
         state       <= ARB_IDLE;
         last_owner  <= IDX_WIDTH'(NUM_MASTERS - 1);
         xfer_cnt    <= '0;
         hba_mgrant  <= '0;
         arb_owner   <= '0;
         arb_busy    <= 1'b0;
         arb_preempt <= 1'b0;
      end else begin
         state       <= state_n;
         last_owner  <= last_owner_n;
         xfer_cnt    <= xfer_cnt_n;
         hba_mgrant  <= grant_n;
         arb_owner   <= owner_n;
         arb_busy    <= busy_n;
         arb_preempt <= preempt_n;
      end
   end

endmodule

// File: tb/tb_hba_arbiter.sv
// Self-checking bench for hba_arbiter (NUM_MASTERS=4, MAX_XFERS=8).
module tb_hba_arbiter;

   logic       hba_clk = 1'b0;
   logic       hba_reset_n;
   logic [3:0] master_request;
   logic       master_select;
   logic       hba_xferack;
   logic [3:0] hba_mgrant;
   logic [2:0] arb_owner;
   logic       arb_busy;
   logic       arb_preempt;

   always #5 hba_clk = ~hba_clk;

   hba_arbiter #(
      .NUM_MASTERS (4),
      .MAX_XFERS   (8),
      .IDX_WIDTH   (3)
   ) dut (
      .hba_clk        (hba_clk),
      .hba_reset_n    (hba_reset_n),
      .master_request (master_request),
      .master_select  (master_select),
      .hba_xferack    (hba_xferack),
      .hba_mgrant     (hba_mgrant),
      .arb_owner      (arb_owner),
      .arb_busy       (arb_busy),
      .arb_preempt    (arb_preempt)
   );

   typedef struct {
      string      tag;
      logic [3:0] grant;
      logic       preempt;
   } exp_t;

   exp_t       exp_q[$];
   int         n_chk = 0;
   int         n_err = 0;
   logic [3:0] prev_grant = 4'b0000;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] idx_of(input logic [3:0] oh);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 0; i < 4; i++) begin
         if (oh[i]) r = 3'(i);
      end
      return r;
   endfunction

   // Drive one cycle of inputs, queue what the outputs must be after the
   // edge, then pop and compare once the edge has happened.
   task automatic step(input string tag, input logic [3:0] req, input logic sel,
                       input logic ack, input logic [3:0] exp_grant, input logic exp_pre);
      exp_t       e;
      exp_t       o;
      logic [3:0] rise;
      e.tag     = tag;
      e.grant   = exp_grant;
      e.preempt = exp_pre;
      exp_q.push_back(e);
      master_request = req;
      master_select  = sel;
      hba_xferack    = ack;
      @(posedge hba_clk);
      #1;
      o = exp_q.pop_front();
      chk({o.tag, "/grant"},   32'(hba_mgrant),  32'(o.grant));
      chk({o.tag, "/busy"},    32'(arb_busy),    32'(|o.grant));
      chk({o.tag, "/preempt"}, 32'(arb_preempt), 32'(o.preempt));
      if (|o.grant) chk({o.tag, "/owner"}, 32'(arb_owner), 32'(idx_of(o.grant)));
      chk({o.tag, "/onehot0"}, 32'($onehot0(hba_mgrant)), 32'd1);
      rise = hba_mgrant & ~prev_grant;
      if (|rise) chk({o.tag, "/grant_wo_req"}, 32'(|(rise & ~req)), 32'd0);
      prev_grant = hba_mgrant;
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic do_reset(input string tag);
      master_request = 4'b0000;
      master_select  = 1'b0;
      hba_xferack    = 1'b0;
      #2 hba_reset_n = 1'b0;
      #1;
      chk({tag, "/rst_grant"},   32'(hba_mgrant),  32'd0);
      chk({tag, "/rst_busy"},    32'(arb_busy),    32'd0);
      chk({tag, "/rst_owner"},   32'(arb_owner),   32'd0);
      chk({tag, "/rst_preempt"}, 32'(arb_preempt), 32'd0);
      #2 hba_reset_n = 1'b1;
      prev_grant = 4'b0000;
   endtask

   initial begin
      hba_reset_n    = 1'b0;
      master_request = 4'b0000;
      master_select  = 1'b0;
      hba_xferack    = 1'b0;
      @(posedge hba_clk);
      #1;

      // 1: single request, one-cycle latency, release
      do_reset("t1");
      step("t1_grant",   4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0);
      step("t1_release", 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
      step("t1_idle",    4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);

      // 2: all request, each owner releases after one transfer
      do_reset("t2");
      step("t2_first", 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b0);
      for (int k = 0; k < 5; k++) begin
         int idx;
         idx = k % 4;
         step($sformatf("t2_xfer%0d", k), 4'b1111, 1'b1, 1'b1, 4'(1 << idx), 1'b0);
         step($sformatf("t2_gap%0d", k), 4'b1111 & ~4'(1 << idx), 1'b0, 1'b0, 4'b0000, 1'b0);
         if (k < 4)
            step($sformatf("t2_next%0d", k), 4'b1111, 1'b0, 1'b0, 4'(1 << ((idx + 1) % 4)), 1'b0);
      end
      step("t2_idle", 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);

      // 3: quota preemption after the 8th xferack, preempted master re-granted
      do_reset("t3");
      step("t3_grant", 4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0);
      for (int j = 1; j <= 8; j++) begin
         step($sformatf("t3_ack%0d", j), 4'b0110, 1'b1, 1'b1,
              (j == 8) ? 4'b0000 : 4'b0010, (j == 8) ? 1'b1 : 1'b0);
      end
      step("t3_m2",      4'b0110, 1'b0, 1'b0, 4'b0100, 1'b0);
      step("t3_m2_rel",  4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0);
      step("t3_m1_back", 4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0);
      step("t3_m1_rel",  4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
      step("t3_idle",    4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);

      // 4: lone requester is never preempted
      do_reset("t4");
      step("t4_grant", 4'b1000, 1'b0, 1'b0, 4'b1000, 1'b0);
      for (int j = 1; j <= 20; j++) begin
         step($sformatf("t4_ack%0d", j), 4'b1000, 1'b1, 1'b1, 4'b1000, 1'b0);
      end
      step("t4_rel", 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);

      // 5: release held off by select; short pulse from master 2 not latched
      do_reset("t5");
      step("t5_grant",    4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0);
      step("t5_pulse",    4'b0101, 1'b1, 1'b0, 4'b0001, 1'b0);
      step("t5_sel",      4'b0001, 1'b1, 1'b0, 4'b0001, 1'b0);
      step("t5_drop_sel", 4'b0000, 1'b1, 1'b0, 4'b0001, 1'b0);
      step("t5_drop_ack", 4'b0000, 1'b1, 1'b1, 4'b0001, 1'b0);
      step("t5_release",  4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
      step("t5_no_latch", 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);

      // 6: async reset mid-grant, then master 0 beats master 2
      do_reset("t6");
      step("t6_grant", 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b0);
      step("t6_xfer",  4'b0100, 1'b1, 1'b0, 4'b0100, 1'b0);
      do_reset("t6_mid");
      step("t6_prio",  4'b0101, 1'b0, 1'b0, 4'b0001, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
